// File: rtl/press_pulse_generator_if.sv
// Symbol request handshake: the producer offers a short/long symbol,
// and the generator accepts it when its queue has room.
interface press_pulse_generator_if;
    logic req_valid;
    logic req_long;
    logic req_ready;

    modport master (output req_valid, output req_long, input req_ready);
    modport slave  (input req_valid, input req_long, output req_ready);
endinterface

// File: rtl/press_pulse_generator.sv
// Timed press-line generator: queues short/long symbols and plays each one
// as a high pulse of SHORT_TIME/LONG_TIME cycles followed by a GAP_TIME low gap.
module press_pulse_generator #(
    parameter logic [31:0] SHORT_TIME = 32'd50000000,
    parameter logic [31:0] LONG_TIME  = 32'd400000000,
    parameter logic [31:0] GAP_TIME   = 32'd50000000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    press_pulse_generator_if.slave          req,
    input  logic                            clear,
    output logic                            pulse_out,
    output logic                            busy,
    output logic                            done,
    output logic [$clog2(FIFO_DEPTH):0]     level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ON, GAP} state_t;

    state_t           state;
    logic [31:0]      cnt;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             fifo_mem [FIFO_DEPTH];
    logic             head_long;
    logic             push;
    logic             pop;

    // Counter preload for a symbol's high phase; the counter runs DUR-1 down to 0.
    function automatic logic [31:0] dur_m1(input logic is_long);
        return (is_long ? LONG_TIME : SHORT_TIME) - 32'd1;
    endfunction

    assign req.req_ready = (level != FULL) && !clear;
    assign push          = req.req_valid && req.req_ready;
    assign head_long     = fifo_mem[rd_ptr];
    // Pop only from registered level, so a symbol pushed this edge waits one cycle.
    assign pop = !clear && (level != '0) &&
                 ((state == IDLE) || ((state == GAP) && (cnt == 32'd0)));
    assign busy = (state != IDLE) || (level != '0);

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= req.req_long;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            pulse_out <= 1'b0;
            done      <= 1'b0;
            level     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else if (clear) begin
            state     <= IDLE;
            cnt       <= '0;
            pulse_out <= 1'b0;
            done      <= 1'b0;
            level     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            done <= 1'b0;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      level <= level + LVL_W'(1);
            else if (!push && pop) level <= level - LVL_W'(1);

            case (state)
                IDLE: begin
                    if (pop) begin
                        cnt       <= dur_m1(head_long);
                        pulse_out <= 1'b1;
                        state     <= ON;
                    end
                end
                ON: begin
                    if (cnt != 32'd0) begin
                        cnt <= cnt - 32'd1;
                    end else begin
                        pulse_out <= 1'b0;
                        cnt       <= GAP_TIME - 32'd1;
                        state     <= GAP;
                    end
                end
                GAP: begin
                    if (cnt != 32'd0) begin
                        cnt <= cnt - 32'd1;
                    end else begin
                        // Gap finished: chain straight into the next queued symbol.
                        done <= 1'b1;
                        if (pop) begin
                            cnt       <= dur_m1(head_long);
                            pulse_out <= 1'b1;
                            state     <= ON;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_press_pulse_generator.sv
// Directed bench for press_pulse_generator with SHORT=3, LONG=8, GAP=2, DEPTH=4.
module tb_press_pulse_generator;

    logic       clk;
    logic       reset;
    logic       clear;
    logic       pulse_out;
    logic       busy;
    logic       done;
    logic [2:0] level;
    int         errors;
    int         checks;
    int         lv;

    press_pulse_generator_if bus ();

    press_pulse_generator #(
        .SHORT_TIME (32'd3),
        .LONG_TIME  (32'd8),
        .GAP_TIME   (32'd2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (bus),
        .clear     (clear),
        .pulse_out (pulse_out),
        .busy      (busy),
        .done      (done),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit i of pexp/dexp is the expected pulse_out/done after the (i+1)th edge.
    task automatic run_pattern(input string tag, input int n,
                               input logic [63:0] pexp, input logic [63:0] dexp);
        for (int i = 0; i < n; i++) begin
            tick();
            check($sformatf("%s_pulse[%0d]", tag, i), 32'(pulse_out), 32'(pexp[i]));
            check($sformatf("%s_done[%0d]", tag, i), 32'(done), 32'(dexp[i]));
        end
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        reset         = 1'b0;
        clear         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_long  = 1'b0;

        // Reset held
        tick(); tick();
        check("rst_pulse", 32'(pulse_out), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        tick();
        check("rel_pulse", 32'(pulse_out), 32'd0);
        check("rel_level", 32'(level), 32'd0);
        check("rel_busy", 32'(busy), 32'd0);

        // Single short symbol
        bus.req_valid = 1'b1; bus.req_long = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        check("t2_level_push", 32'(level), 32'd1);
        check("t2_pulse_push", 32'(pulse_out), 32'd0);
        check("t2_busy_push", 32'(busy), 32'd1);
        run_pattern("t2", 7, 64'h07, 64'h20);
        check("t2_busy_end", 32'(busy), 32'd0);
        check("t2_level_end", 32'(level), 32'd0);

        // Long, short, long back-to-back
        bus.req_valid = 1'b1; bus.req_long = 1'b1;
        tick();
        check("t3_level0", 32'(level), 32'd1);
        bus.req_long = 1'b0;
        tick();
        check("t3_level1", 32'(level), 32'd1);
        check("t3_pulse1", 32'(pulse_out), 32'd1);
        bus.req_long = 1'b1;
        tick();
        check("t3_level2", 32'(level), 32'd2);
        bus.req_valid = 1'b0;
        run_pattern("t3", 25, 64'h1FE73F, 64'h802100);
        check("t3_busy_end", 32'(busy), 32'd0);

        // Fill the queue while a long pulse is in progress
        bus.req_valid = 1'b1; bus.req_long = 1'b1;
        tick();
        check("t4_lvl_f0", 32'(level), 32'd1);
        bus.req_long = 1'b0;
        tick();
        check("t4_lvl_f1", 32'(level), 32'd1);
        bus.req_long = 1'b1;
        tick();
        check("t4_lvl_f2", 32'(level), 32'd2);
        bus.req_long = 1'b0;
        tick();
        check("t4_lvl_f3", 32'(level), 32'd3);
        bus.req_long = 1'b1;
        tick();
        check("t4_lvl_f4", 32'(level), 32'd4);
        check("t4_ready_full", 32'(bus.req_ready), 32'd0);
        bus.req_long = 1'b0;
        tick();
        check("t4_lvl_f5", 32'(level), 32'd4);
        tick();
        check("t4_lvl_f6", 32'(level), 32'd4);
        bus.req_valid = 1'b0;
        lv = 4;
        for (int i = 0; i < 36; i++) begin
            logic [63:0] pexp;
            logic [63:0] dexp;
            pexp = 64'hFF39FE73;
            dexp = 64'h401080210;
            tick();
            if (i == 4 || i == 9 || i == 19 || i == 24) lv--;
            check($sformatf("t4_pulse[%0d]", i), 32'(pulse_out), 32'(pexp[i]));
            check($sformatf("t4_done[%0d]", i), 32'(done), 32'(dexp[i]));
            check($sformatf("t4_level[%0d]", i), 32'(level), 32'(lv));
        end
        check("t4_busy_end", 32'(busy), 32'd0);

        // Push and pop on the same edge, pointers wrapping
        bus.req_valid = 1'b1; bus.req_long = 1'b0;
        tick();
        check("t6_lvl_h0", 32'(level), 32'd1);
        bus.req_long = 1'b1;
        tick();
        check("t6_lvl_h1", 32'(level), 32'd1);
        bus.req_long = 1'b0;
        tick();
        check("t6_lvl_h2", 32'(level), 32'd2);
        bus.req_valid = 1'b0;
        tick(); tick(); tick();
        check("t6_lvl_h5", 32'(level), 32'd2);
        bus.req_valid = 1'b1; bus.req_long = 1'b1;
        tick();
        check("t6_lvl_h6", 32'(level), 32'd2);
        check("t6_done_h6", 32'(done), 32'd1);
        check("t6_pulse_h6", 32'(pulse_out), 32'd1);
        bus.req_long = 1'b0;
        tick();
        check("t6_lvl_h7", 32'(level), 32'd3);
        bus.req_valid = 1'b0;
        run_pattern("t6", 30, 64'h39FE73F, 64'h10802100);
        check("t6_busy_end", 32'(busy), 32'd0);

        // Clear during the second cycle of a long pulse with two symbols queued
        bus.req_valid = 1'b1; bus.req_long = 1'b1;
        tick();
        bus.req_long = 1'b0;
        tick();
        tick();
        check("t5_lvl_g2", 32'(level), 32'd2);
        check("t5_pulse_g2", 32'(pulse_out), 32'd1);
        clear = 1'b1;
        #1;
        check("t5_ready_clear", 32'(bus.req_ready), 32'd0);
        tick();
        clear = 1'b0;
        bus.req_valid = 1'b0;
        check("t5_pulse_g3", 32'(pulse_out), 32'd0);
        check("t5_level_g3", 32'(level), 32'd0);
        check("t5_done_g3", 32'(done), 32'd0);
        check("t5_busy_g3", 32'(busy), 32'd0);
        run_pattern("t5", 6, 64'h0, 64'h0);
        check("t5_level_end", 32'(level), 32'd0);

        // Async reset in the middle of a pulse
        bus.req_valid = 1'b1; bus.req_long = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        tick();
        check("ar_pulse_before", 32'(pulse_out), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("ar_pulse_async", 32'(pulse_out), 32'd0);
        check("ar_busy_async", 32'(busy), 32'd0);
        check("ar_level_async", 32'(level), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        check("ar_pulse_after", 32'(pulse_out), 32'd0);
        check("ar_ready_after", 32'(bus.req_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/press_pulse_generator.md
Name: press_pulse_generator

Overview:
- Produces timed press pulses: the inverse of the short/long press detector.
- Takes short/long symbol requests over a valid/ready handshake and queues them in a small FIFO.
- Drives a single line high for SHORT_TIME or LONG_TIME cycles per symbol, with a fixed low gap after each.
- Used for buzzer/LED feedback and as a stimulus source for the press detector, so LONG_TIME exceeds the detector's long threshold.

Parameters:
- SHORT_TIME, 32'd50000000: high duration of a short symbol, in clk cycles; must be >= 1.
- LONG_TIME, 32'd400000000: high duration of a long symbol, in clk cycles; must be >= 1.
- GAP_TIME, 32'd50000000: low duration after every symbol, in clk cycles; must be >= 1.
- FIFO_DEPTH, 4: symbol queue entries; must be a power of two, >= 2.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- req_valid  input  1  symbol request present.
- req_long  input  1  symbol type: 1 = long, 0 = short; sampled with req_valid.
- req_ready  output  1  FIFO can accept a symbol this cycle.
- clear  input  1  synchronous flush/abort.
- pulse_out  output  1  generated press line, registered.
- busy  output  1  high when the FSM is not IDLE or the FIFO is non-empty.
- done  output  1  one-cycle pulse when a symbol's gap completes.
- level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset=0, async):
  - FIFO emptied; level=0.
  - FSM in IDLE; duration counter=0.
  - pulse_out=0, done=0, busy=0, req_ready=1.
- Handshake and FIFO:
  - req_ready = (level != FIFO_DEPTH) && !clear; combinational from registered level.
  - A push occurs on an edge where req_valid && req_ready; req_long is stored.
  - When full, req_valid is ignored; the symbol is not stored and no error is flagged.
  - No bypass: a push into an empty FIFO is popped no earlier than the following edge.
  - Push and pop on the same edge leave level unchanged; read/write pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE: if level != 0, pop the head symbol, load cnt = DUR-1 (DUR = LONG_TIME if the symbol is long, else SHORT_TIME), set pulse_out=1, go ON.
  - ON: pulse_out=1. While cnt != 0, decrement cnt. At cnt == 0, set pulse_out=0, load cnt = GAP_TIME-1, go GAP.
  - GAP: pulse_out=0. While cnt != 0, decrement cnt. At cnt == 0, assert done for one cycle; then:
    - if level != 0, pop, load the new DUR-1, set pulse_out=1, go ON (back-to-back, no idle cycle);
    - otherwise go IDLE.
- Timing:
  - pulse_out is high for exactly DUR cycles and low for exactly GAP_TIME cycles per symbol.
  - Symbol period is DUR + GAP_TIME.
  - Latency: a push at edge N into an empty FIFO with FSM in IDLE raises pulse_out at edge N+1.
- Counter: 32-bit down-counter, no wrap; parameters of 0 are illegal.
- clear (sync, highest priority after reset):
  - FIFO flushed; level=0.
  - FSM to IDLE; pulse_out=0; done=0; cnt=0.
  - Any simultaneous request is dropped, since req_ready=0.
  - Clear mid-ON truncates the pulse immediately; no done for the aborted symbol.
- Async reset mid-pulse: pulse_out drops immediately, without waiting for a clock edge.
- busy = (state != IDLE) || (level != 0).

Test Plan:
All scenarios use SHORT_TIME=3, LONG_TIME=8, GAP_TIME=2, FIFO_DEPTH=4.
1. Reset held, then released:
   - pulse_out=0, done=0, level=0, req_ready=1, busy=0.
   - Async reset asserted mid-ON drops pulse_out before the next clk edge.
2. Single short push at edge N:
   - pulse_out high at edges N+1..N+3 (3 cycles), low for 2 cycles.
   - done pulses one cycle at the end of the gap; busy returns to 0.
3. Push long, short, long back-to-back:
   - pulse_out pattern 8 high, 2 low, 3 high, 2 low, 8 high, 2 low, with no extra idle cycles.
   - Three done pulses.
4. Hold req_valid with FSM stalled in a long pulse:
   - 4 further symbols accepted, level=4, req_ready=0.
   - A 6th request is ignored.
   - level decrements on each pop; all 4 symbols emitted in order.
5. Assert clear during the 2nd cycle of a long pulse with 2 symbols queued:
   - Next edge: pulse_out=0, level=0, no done, busy=0.
   - A push on the clear cycle is not accepted.
6. Push and pop on the same edge with level=2:
   - level stays 2; after 4 pushes with pointer wrap, emitted symbol order matches push order.
